// File: rtl/amns_pkg.sv
// -----------------------------------------------------------------------------
// amns_pkg
// Shared definitions for the AMNS limb normalizer:
//   - default limb and accumulator widths
//   - helpers that derive the carry width and the number of flush limbs
//   - the normalizer FSM state type
// -----------------------------------------------------------------------------
package amns_pkg;

   localparam int LIMB_W_DEF = 17;
   localparam int ACC_W_DEF  = 48;

   // Width of the carry left over after a limb has been peeled off an
   // (ACC_W+1)-bit sum.
   function automatic int calc_carry_w(input int acc_w, input int limb_w);
      return acc_w + 1 - limb_w;
   endfunction

   // Number of limbs needed to drain a full carry register: ceil(CARRY_W/LIMB_W).
   function automatic int calc_flush_n(input int acc_w, input int limb_w);
      return (calc_carry_w(acc_w, limb_w) + limb_w - 1) / limb_w;
   endfunction

   // Counter width for 0..FLUSH_N-1, never narrower than one bit.
   function automatic int calc_cnt_w(input int flush_n);
      return (flush_n <= 2) ? 1 : $clog2(flush_n);
   endfunction

   typedef enum logic {
      STREAM = 1'b0,
      FLUSH  = 1'b1
   } norm_state_t;

endpackage

// File: rtl/amns_norm_outreg.sv
// -----------------------------------------------------------------------------
// amns_norm_outreg
// One-entry output register for a valid/ready stream stage. The entry holds
// data and last while o_valid && !i_ready; it empties when accepted and no new
// word is loaded.
//
// Handshake: a beat transfers on a rising edge where o_valid && i_ready. The
// producer may assert i_load only while o_free is high, i.e. the entry is empty
// or is being accepted on this same edge.
//
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : write i_data/i_last into the entry this edge
//   i_data, i_last : word and end-of-operand flag to store
//   i_ready        : downstream accepts the current entry
//   o_data, o_last : registered word and flag
//   o_valid        : entry holds a word
//   o_free         : entry may be (re)loaded this cycle
// -----------------------------------------------------------------------------
module amns_norm_outreg #(
   parameter int W = 17
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_data,
   input  logic         i_last,
   input  logic         i_ready,
   output logic [W-1:0] o_data,
   output logic         o_last,
   output logic         o_valid,
   output logic         o_free
);

   logic [W-1:0] r_data;
   logic         r_last;
   logic         r_valid;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_data  <= '0;
         r_last  <= 1'b0;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_data  <= i_data;
         r_last  <= i_last;
         r_valid <= 1'b1;
      end else if (i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_data  = r_data;
   assign o_last  = r_last;
   assign o_valid = r_valid;
   assign o_free  = !r_valid || i_ready;

endmodule

// File: rtl/amns_limb_normalizer.sv
// -----------------------------------------------------------------------------
// amns_limb_normalizer
// Consumes the stream of ACC_W-bit accumulator words from the last PE (least
// significant word first), propagates carries between words and emits
// LIMB_W-bit limbs. After the word flagged res_last_i it appends FLUSH_N limbs
// drawn from the remaining carry, the final one flagged limb_last_o. Every
// operand therefore produces N_words + FLUSH_N limbs.
//
// Handshake (both sides): a beat transfers on a rising edge where valid and
// ready are both high; a producer holding valid keeps its data stable until
// that edge. res_ready_o is high only in STREAM and only when the output
// register is empty or draining; it is low throughout FLUSH.
//
// Configuration macro: AMNS_NORM_SIGNED_EN
//   defined   : words and carry are two's complement, the carry shifts
//               arithmetically (signed AMNS coefficients)
//   undefined : unsigned arithmetic
//
// Ports:
//   clock_i, reset_n_i : clock, asynchronous active-low reset
//   res_valid_i, res_dout_i, res_last_i, res_ready_o : accumulator word input
//   limb_o, limb_valid_o, limb_last_o, limb_ready_i  : normalized limb output
//   dbg_state_o        : current FSM state, for observation only
// -----------------------------------------------------------------------------
module amns_limb_normalizer
   import amns_pkg::*;
#(
   parameter int LIMB_W = LIMB_W_DEF,
   parameter int ACC_W  = ACC_W_DEF
) (
   input  logic              clock_i,
   input  logic              reset_n_i,
   input  logic              res_valid_i,
   input  logic [ACC_W-1:0]  res_dout_i,
   input  logic              res_last_i,
   output logic              res_ready_o,
   output logic [LIMB_W-1:0] limb_o,
   output logic              limb_valid_o,
   output logic              limb_last_o,
   input  logic              limb_ready_i,
   output norm_state_t       dbg_state_o
);

   localparam int CARRY_W = calc_carry_w(ACC_W, LIMB_W);
   localparam int FLUSH_N = calc_flush_n(ACC_W, LIMB_W);
   localparam int CNT_W   = calc_cnt_w(FLUSH_N);
   localparam int SUM_W   = ACC_W + 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_N - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   norm_state_t          r_state;
   norm_state_t          w_state_nxt;
   logic [CARRY_W-1:0]   r_carry;
   logic [CARRY_W-1:0]   w_carry_nxt;
   logic [CNT_W-1:0]     r_flush_cnt;
   logic [CNT_W-1:0]     w_flush_cnt_nxt;

   logic [SUM_W-1:0]     w_sum;
   // Carry widened to SUM_W bits so the low limb and the shifted remainder can
   // be sliced out directly even when CARRY_W < LIMB_W.
   logic [SUM_W-1:0]     w_carry_ext;

   logic                 w_free;
   logic                 w_accept;
   logic                 w_load;
   logic [LIMB_W-1:0]    w_limb_d;
   logic                 w_last_d;

`ifdef AMNS_NORM_SIGNED_EN
   assign w_sum       = {res_dout_i[ACC_W-1], res_dout_i}
                      + {{LIMB_W{r_carry[CARRY_W-1]}}, r_carry};
   assign w_carry_ext = {{LIMB_W{r_carry[CARRY_W-1]}}, r_carry};
`else
   assign w_sum       = {1'b0, res_dout_i} + {{LIMB_W{1'b0}}, r_carry};
   assign w_carry_ext = {{LIMB_W{1'b0}}, r_carry};
`endif

   assign res_ready_o = (r_state == STREAM) && w_free;
   assign w_accept    = res_valid_i && res_ready_o;
   assign dbg_state_o = r_state;

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state     <= STREAM;
         r_carry     <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_carry     <= w_carry_nxt;
         r_flush_cnt <= w_flush_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_carry_nxt     = r_carry;
      w_flush_cnt_nxt = r_flush_cnt;
      w_load          = 1'b0;
      w_limb_d        = '0;
      w_last_d        = 1'b0;

      case (r_state)
         STREAM: begin
            if (w_accept) begin
               w_load      = 1'b1;
               w_limb_d    = w_sum[LIMB_W-1:0];
               // The top CARRY_W bits of the sum are exactly sum >> LIMB_W;
               // in signed mode they are also the arithmetic shift.
               w_carry_nxt = w_sum[SUM_W-1:LIMB_W];
               if (res_last_i) begin
                  w_state_nxt     = FLUSH;
                  w_flush_cnt_nxt = '0;
               end
            end
         end

         FLUSH: begin
            if (w_free) begin
               w_load          = 1'b1;
               w_limb_d        = w_carry_ext[LIMB_W-1:0];
               w_carry_nxt     = w_carry_ext[LIMB_W +: CARRY_W];
               w_flush_cnt_nxt = r_flush_cnt + CNT_ONE;
               // Fixed limb count: no early exit when the carry hits zero.
               if (r_flush_cnt == CNT_LAST) begin
                  w_last_d        = 1'b1;
                  w_state_nxt     = STREAM;
                  w_carry_nxt     = '0;
                  w_flush_cnt_nxt = '0;
               end
            end
         end

         default: begin
            w_state_nxt = STREAM;
         end
      endcase
   end

   amns_norm_outreg #(
      .W (LIMB_W)
   ) u_outreg (
      .i_clk   (clock_i),
      .i_rst_n (reset_n_i),
      .i_load  (w_load),
      .i_data  (w_limb_d),
      .i_last  (w_last_d),
      .i_ready (limb_ready_i),
      .o_data  (limb_o),
      .o_last  (limb_last_o),
      .o_valid (limb_valid_o),
      .o_free  (w_free)
   );

endmodule
